led_capture: RTL and testbench

- Receive-side monitor for RGB LED drive lines.
- Samples the three LED signals produced by the LED driver blocks over fixed windows of WINDOW clocks.
- For each colour, reports the high-time count and the rising-edge count once per window, through a valid/ready handshake.
- Used in simulation benches and on-chip self-check to measure duty cycle and blink rate of the LED drivers.

---
 rtl/led_capture.sv | 132 +++++++++++++
 tb/tb_led_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_capture.sv
// Receive-side monitor for RGB LED drive lines: counts high cycles and rising
// edges per colour over WINDOW-clock windows and hands each result set out over valid/ready.
module led_capture #(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 16,
    parameter int EDGE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              led_red,
    input  logic              led_green,
    input  logic              led_blue,
    output logic [CNT_W-1:0]  cap_red,
    output logic [CNT_W-1:0]  cap_green,
    output logic [CNT_W-1:0]  cap_blue,
    output logic [EDGE_W-1:0] edges_red,
    output logic [EDGE_W-1:0] edges_green,
    output logic [EDGE_W-1:0] edges_blue,
    output logic              cap_valid,
    input  logic              cap_ready,
    output logic              overrun
);

    localparam logic [0:0]        IDLE     = 1'b0;
    localparam logic [0:0]        RUN      = 1'b1;
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WINDOW - 1);
    localparam logic [EDGE_W-1:0] EDGE_MAX = '1;

    // Channel index: 0 = red, 1 = green, 2 = blue.
    logic [2:0]        sync1;
    logic [2:0]        s;
    logic [2:0]        prev;
    logic [2:0]        rise;
    logic [0:0]        state;
    logic [CNT_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  high_acc [3];
    logic [EDGE_W-1:0] edge_acc [3];
    logic [CNT_W-1:0]  high_tot [3];
    logic [EDGE_W-1:0] edge_tot [3];
    logic              close;
    logic              transfer;
    logic              load;
    logic              drop;

    assign rise = s & ~prev;

    // Totals including the current cycle's sample; used both to accumulate and to deliver at close.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        for (int i = 0; i < 3; i++) begin
            high_tot[i] = high_acc[i] + CNT_W'(s[i]);
            edge_tot[i] = edge_acc[i];
            if (rise[i] && (edge_acc[i] != EDGE_MAX)) begin
                edge_tot[i] = edge_acc[i] + EDGE_W'(1);
            end
        end
    end

    assign close    = (state == RUN) && en && (win_cnt == LAST);
    assign transfer = cap_valid && cap_ready;
    assign load     = close && (!cap_valid || cap_ready);
    assign drop     = close && cap_valid && !cap_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            s       <= '0;
            prev    <= '0;
            state   <= IDLE;
            win_cnt <= '0;
            for (int i = 0; i < 3; i++) begin
                high_acc[i] <= '0;
                edge_acc[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1 <= {led_blue, led_green, led_red};
            s     <= sync1;
            prev  <= s;
            if ((state == RUN) && en && !close) begin
                win_cnt <= win_cnt + CNT_W'(1);
                for (int i = 0; i < 3; i++) begin
                    high_acc[i] <= high_tot[i];
                    edge_acc[i] <= edge_tot[i];
                end
            end else begin
                win_cnt <= '0;
                for (int i = 0; i < 3; i++) begin
                    high_acc[i] <= '0;
                    edge_acc[i] <= '0;
                end
            end
            case (state)
                IDLE:    if (en)  state <= RUN;
                RUN:     if (!en) state <= IDLE;
                default:          state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_red     <= '0;
            cap_green   <= '0;
            cap_blue    <= '0;
            edges_red   <= '0;
            edges_green <= '0;
            edges_blue  <= '0;
            cap_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                cap_red     <= high_tot[0];
                cap_green   <= high_tot[1];
                cap_blue    <= high_tot[2];
                edges_red   <= edge_tot[0];
                edges_green <= edge_tot[1];
                edges_blue  <= edge_tot[2];
                cap_valid   <= 1'b1;
            end else if (transfer) begin
                cap_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (transfer) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_capture.sv
// Scoreboard bench for led_capture: expected result sets are queued as stimulus is
// applied and compared at each handshake; a second instance checks edge-count saturation.
module tb_led_capture;

    localparam int WINDOW = 10;
    localparam int CNT_W  = 8;
    localparam int EDGE_W = 4;
    localparam int SAT_W  = 2;

    logic clk;
    logic rst;
    logic en;
    logic led_red;
    logic led_green;
    logic led_blue;
    logic cap_ready;

    logic [CNT_W-1:0]  cap_red, cap_green, cap_blue;
    logic [EDGE_W-1:0] edges_red, edges_green, edges_blue;
    logic              cap_valid, overrun;

    logic [CNT_W-1:0] s_cap_red, s_cap_green, s_cap_blue;
    logic [SAT_W-1:0] s_edges_red, s_edges_green, s_edges_blue;
    logic             s_cap_valid, s_overrun;

    typedef struct {
        int r;
        int g;
        int b;
        int er;
        int eg;
        int eb;
        int sat_eg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   ph = 0;
    int   e_cyc;
    int   v_cyc;
    logic red_lvl = 1'b1;
    logic patt_on = 1'b1;
    logic saw_v;

    led_capture #(.WINDOW(WINDOW), .CNT_W(CNT_W), .EDGE_W(EDGE_W)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
        .cap_red(cap_red), .cap_green(cap_green), .cap_blue(cap_blue),
        .edges_red(edges_red), .edges_green(edges_green), .edges_blue(edges_blue),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .overrun(overrun)
    );

    led_capture #(.WINDOW(WINDOW), .CNT_W(CNT_W), .EDGE_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .en(en),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
        .cap_red(s_cap_red), .cap_green(s_cap_green), .cap_blue(s_cap_blue),
        .edges_red(s_edges_red), .edges_green(s_edges_green), .edges_blue(s_edges_blue),
        .cap_valid(s_cap_valid), .cap_ready(cap_ready), .overrun(s_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cap_valid && (n < max_cyc));
        check("valid_seen", 32'(cap_valid), 32'd1);
    endtask

    function automatic exp_t all_patterns();
        // Red steady high, green toggling, blue 3-high/7-low: per-window results independent of phase.
        return exp_t'{r: 10, g: 5, b: 3, er: 0, eg: 5, eb: 1, sat_eg: 3};
    endfunction

    // LED pattern generator, updated just after each rising edge.
    initial begin
        led_red   = 1'b1;
        led_green = 1'b0;
        led_blue  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            led_red = red_lvl;
            if (patt_on) begin
                led_green = ~led_green;
                led_blue  = (ph < 3);
                ph        = (ph + 1) % 10;
            end else begin
                led_green = 1'b0;
                led_blue  = 1'b0;
            end
        end
    end

    // Handshake monitor: a transfer happens on the next edge, so compare against the scoreboard now.
    initial forever begin
        @(negedge clk);
        if (!rst && cap_valid && cap_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("cap_red",         32'(cap_red),       32'(mon_e.r));
                check("cap_green",       32'(cap_green),     32'(mon_e.g));
                check("cap_blue",        32'(cap_blue),      32'(mon_e.b));
                check("edges_red",       32'(edges_red),     32'(mon_e.er));
                check("edges_green",     32'(edges_green),   32'(mon_e.eg));
                check("edges_blue",      32'(edges_blue),    32'(mon_e.eb));
                check("sat_edges_green", 32'(s_edges_green), 32'(mon_e.sat_eg));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cap_ready = 1'b1;
        tick();
        check("rst_caps",  {8'd0, cap_red, cap_green, cap_blue}, 32'd0);
        check("rst_edges", 32'({edges_red, edges_green, edges_blue}), 32'd0);
        check("rst_valid", 32'({cap_valid, overrun, s_cap_valid}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // Free-running windows with the consumer always ready: 1-cycle valid pulse every 10 clocks.
        repeat (4) sb.push_back(all_patterns());
        en    = 1'b1;
        e_cyc = cyc;
        wait_valid(20);
        check("first_latency", 32'(cyc - e_cyc), 32'd11);
        v_cyc = cyc;
        repeat (2) begin
            tick();
            check("valid_pulse", 32'(cap_valid), 32'd0);
            wait_valid(20);
            check("valid_period", 32'(cyc - v_cyc), 32'd10);
            v_cyc = cyc;
        end

        // Drop en at window count 6, re-enable 3 clocks later: partial window discarded.
        saw_v = 1'b0;
        repeat (6) begin
            tick();
            saw_v |= cap_valid;
        end
        en = 1'b0;
        repeat (3) begin
            tick();
            saw_v |= cap_valid;
        end
        check("no_partial", 32'(saw_v), 32'd0);
        en    = 1'b1;
        e_cyc = cyc;
        wait_valid(20);
        check("reentry_latency", 32'(cyc - e_cyc), 32'd11);
        tick();
        en = 1'b0;

        // Stalled consumer: first set held, later windows dropped, overrun raised then cleared.
        patt_on   = 1'b0;
        red_lvl   = 1'b1;
        cap_ready = 1'b0;
        repeat (5) tick();
        sb.push_back(exp_t'{r: 10, g: 0, b: 0, er: 0, eg: 0, eb: 0, sat_eg: 0});
        sb.push_back(exp_t'{r: 0, g: 0, b: 0, er: 0, eg: 0, eb: 0, sat_eg: 0});
        en = 1'b1;
        wait_valid(20);
        check("ovr_before_drop", 32'(overrun), 32'd0);
        red_lvl = 1'b0;
        repeat (10) tick();
        check("ovr_set",       32'(overrun),   32'd1);
        check("ovr_held_v",    32'(cap_valid), 32'd1);
        check("ovr_held_red",  32'(cap_red),   32'd10);
        repeat (15) tick();
        cap_ready = 1'b1;
        tick();
        check("ovr_xfer_valid", 32'(cap_valid), 32'd0);
        check("ovr_cleared",    32'(overrun),   32'd0);
        wait_valid(10);
        tick();
        en = 1'b0;

        // Asynchronous reset while a result is held and overrun is set.
        patt_on   = 1'b1;
        red_lvl   = 1'b1;
        cap_ready = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        wait_valid(20);
        repeat (10) tick();
        check("pre_rst_ovr", 32'(overrun), 32'd1);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("arst_caps",  {8'd0, cap_red, cap_green, cap_blue}, 32'd0);
        check("arst_edges", 32'({edges_red, edges_green, edges_blue}), 32'd0);
        check("arst_valid", 32'({cap_valid, overrun, s_cap_valid}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        cap_ready = 1'b1;
        sb.push_back(all_patterns());
        en    = 1'b1;
        e_cyc = cyc;
        wait_valid(20);
        check("post_rst_latency", 32'(cyc - e_cyc), 32'd11);
        tick();
        en = 1'b0;
        repeat (5) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
